// File: rtl/board_sensor_scanner_if.sv
// Data-memory read bus between the processor/RAM manager and the board sensor
// scanner. The processor side drives the address; the scanner returns the
// registered read data that the RAM manager muxes onto q_dmem.
interface board_sensor_scanner_if;
  logic [31:0] addr;
  logic [31:0] sensorDataOut;

  modport master (
    output addr,
    input  sensorDataOut
  );

  modport slave (
    input  addr,
    output sensorDataOut
  );
endinterface

// File: rtl/board_sensor_scanner.sv
// Board sensor scanner: walks an external N:1 sensor mux over the playable
// squares, synchronizes the comparator output, debounces each square across
// full scans and exposes the stable occupancy bitmap plus a status word as
// memory-mapped read data with RAM-like one-cycle latency.
module board_sensor_scanner #(
  parameter int unsigned SQUARES        = 32,
  parameter int unsigned SETTLE_CYCLES  = 50,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter logic [11:0] BASE_ADDR      = 12'hF00,
  localparam int unsigned SEL_W         = $clog2(SQUARES)
) (
  input  logic                   clock,
  input  logic                   reset,
  board_sensor_scanner_if.slave  bus,
  input  logic                   sense_in,
  output logic [SEL_W-1:0]       sel_out,
  output logic                   scan_done,
  output logic                   changed
);

  // Counter widths: settle counter holds 0..SETTLE_CYCLES-1, debounce
  // counters hold 0..DEBOUNCE_SCANS-1 (at least one bit).
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned DB_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(SQUARES - 1);
  localparam logic [SEL_W-1:0] SEL_ONE     = SEL_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
  localparam logic [11:0]      STATUS_ADDR = BASE_ADDR + 12'd1;
  // Bits at positions >= SQUARES always read as zero.
  localparam logic [31:0]      SQ_MASK     = 32'hFFFF_FFFF >> (32 - SQUARES);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              settle_q, settle_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic [1:0]                    sync_q, sync_d;
  logic [31:0]                   raw_q, raw_d;
  logic [31:0]                   stable_q, stable_d;
  logic [SQUARES-1:0][DB_W-1:0]  cnt_q, cnt_d;
  logic [15:0]                   scan_count_q, scan_count_d;
  logic                          changed_q, changed_d;
  logic                          scan_done_q, scan_done_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic                          flip_s;
  logic                          occ_read_s;
  logic                          unused_addr_s;

  // Only addr[11:0] is decoded; the upper address bits are intentionally ignored.
  assign unused_addr_s = ^bus.addr[31:12];

  // Two-flop synchronizer for the asynchronous comparator output.
  always_comb begin
    sync_d = {sync_q[0], sense_in};
  end

  // Scan FSM: settle on each select, sample, and debounce-commit after the last square.
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    sel_d        = sel_q;
    raw_d        = raw_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    scan_count_d = scan_count_q;
    flip_s       = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = {CNT_W{1'b0}};
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + CNT_ONE;
        end
      end

      ST_SAMPLE: begin
        raw_d[sel_q] = sync_q[1];
        if (sel_q == SEL_LAST) begin
          sel_d   = {SEL_W{1'b0}};
          state_d = ST_COMMIT;
        end else begin
          sel_d   = sel_q + SEL_ONE;
          state_d = ST_SETTLE;
        end
      end

      ST_COMMIT: begin
        for (int i = 0; i < SQUARES; i++) begin
          if (raw_q[i] == stable_q[i]) begin
            cnt_d[i] = {DB_W{1'b0}};
          end else if (cnt_q[i] == DB_LAST) begin
            stable_d[i] = raw_q[i];
            cnt_d[i]    = {DB_W{1'b0}};
            flip_s      = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DB_ONE;
          end
        end
        scan_count_d = scan_count_q + 16'd1;
        state_d      = ST_SETTLE;
      end

      default: begin
        // Unreachable encoding: restart the scan cleanly.
        state_d  = ST_SETTLE;
        settle_d = {CNT_W{1'b0}};
        sel_d    = {SEL_W{1'b0}};
      end
    endcase

    // Keep bits beyond the sensed squares at zero.
    raw_d    = raw_d & SQ_MASK;
    stable_d = stable_d & SQ_MASK;
  end

  // Read decode and changed-flag update; a flip in the same cycle as an occupancy read wins.
  always_comb begin
    rdata_d    = 32'h0000_0000;
    occ_read_s = 1'b0;
    if (bus.addr[11:0] == BASE_ADDR) begin
      rdata_d    = stable_q & SQ_MASK;
      occ_read_s = 1'b1;
    end else if (bus.addr[11:0] == STATUS_ADDR) begin
      rdata_d = {scan_count_q, 13'b0, state_q, changed_q};
    end else begin
      rdata_d = 32'h0000_0000;
    end

    if (flip_s) begin
      changed_d = 1'b1;
    end else if (occ_read_s) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end

    // scan_done is high exactly during the COMMIT cycle, from a flop.
    scan_done_d = (state_d == ST_COMMIT);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_SETTLE;
      settle_q     <= {CNT_W{1'b0}};
      sel_q        <= {SEL_W{1'b0}};
      sync_q       <= 2'b00;
      raw_q        <= 32'h0000_0000;
      stable_q     <= 32'h0000_0000;
      cnt_q        <= {(SQUARES*DB_W){1'b0}};
      scan_count_q <= 16'h0000;
      changed_q    <= 1'b0;
      scan_done_q  <= 1'b0;
      rdata_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      sel_q        <= sel_d;
      sync_q       <= sync_d;
      raw_q        <= raw_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      scan_count_q <= scan_count_d;
      changed_q    <= changed_d;
      scan_done_q  <= scan_done_d;
      rdata_q      <= rdata_d;
    end
  end

  assign sel_out           = sel_q;
  assign scan_done         = scan_done_q;
  assign changed           = changed_q;
  assign bus.sensorDataOut = rdata_q;

endmodule

// File: tb/tb_board_sensor_scanner.sv
// Directed testbench for board_sensor_scanner with a behavioural sensor mux
// (sense_in = board[sel_out]) and hand-computed expectations.
module tb_board_sensor_scanner;
  localparam logic [31:0] OCC_ADDR  = 32'h0000_0F00;
  localparam logic [31:0] STAT_ADDR = 32'h0000_0F01;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sense_in;
  logic [4:0]  sel_out;
  logic        scan_done;
  logic        changed;
  logic [31:0] board = 32'h0;
  int          total = 0;
  int          bad   = 0;

  board_sensor_scanner_if bus_if ();

  board_sensor_scanner #(
    .SQUARES        (32),
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_SCANS (3),
    .BASE_ADDR      (12'hF00)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_if),
    .sense_in  (sense_in),
    .sel_out   (sel_out),
    .scan_done (scan_done),
    .changed   (changed)
  );

  assign sense_in = board[sel_out];

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus_if.addr = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    bus_if.addr = a;
    tick();
    d = bus_if.sensorDataOut;
    bus_if.addr = 32'h0;
  endtask

  // Returns in the COMMIT cycle (just after scan_done is seen high).
  task automatic wait_scan_done();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!scan_done && n < 200);
    total++;
    if (!scan_done) begin
      bad++;
      $display("FAIL scan_done_timeout: got no pulse in %0d cycles, want a pulse", n);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus_if.addr = OCC_ADDR;
    tick();
    tick();
    total++; if (sel_out !== 5'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel_out); end
    total++; if (bus_if.sensorDataOut !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 00000000", bus_if.sensorDataOut); end
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL reset_changed: got %b want 0", changed); end
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL reset_scan_done: got %b want 0", scan_done); end
    bus_if.addr = 32'h0;
  endtask

  task automatic test_scan_timing();
    board = 32'h0;
    do_reset();
    for (int n = 1; n <= 161; n++) begin
      tick();
      total++;
      if (scan_done !== (n == 160)) begin
        bad++;
        $display("FAIL scan_done_timing: edge %0d got %b want %b", n, scan_done, (n == 160));
      end
      if (n % 5 == 0 && n <= 155) begin
        total++;
        if (sel_out !== 5'(n / 5)) begin
          bad++;
          $display("FAIL sel_step: edge %0d got %0d want %0d", n, sel_out, n / 5);
        end
      end
      if (n == 160) begin
        total++;
        if (sel_out !== 5'd0) begin bad++; $display("FAIL sel_wrap: got %0d want 0", sel_out); end
      end
    end
  endtask

  task automatic test_debounce_hold();
    logic [31:0] d;
    do_reset();
    board = 32'h0000_0080;
    for (int s = 1; s <= 3; s++) begin
      wait_scan_done();
      tick();
      if (s < 3) begin
        read_reg(OCC_ADDR, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL hold_early_occ: scan %0d got %h want 00000000", s, d); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL hold_early_changed: scan %0d got %b want 0", s, changed); end
      end else begin
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL hold_changed_set: got %b want 1", changed); end
        read_reg(STAT_ADDR, d);
        total++; if (d !== 32'h0003_0001) begin bad++; $display("FAIL hold_status: got %h want 00030001", d); end
        read_reg(32'hABC0_0F00, d);
        total++; if (d !== 32'h0000_0080) begin bad++; $display("FAIL hold_occ: got %h want 00000080", d); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL hold_changed_clear: got %b want 0", changed); end
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    read_reg(32'h0000_0F02, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL decode_f02: got %h want 00000000", d); end
    read_reg(32'h0000_0EFF, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL decode_eff: got %h want 00000000", d); end
    read_reg(32'h0000_0000, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL decode_000: got %h want 00000000", d); end
  endtask

  task automatic test_toggle();
    logic [31:0] d;
    do_reset();
    for (int s = 1; s <= 6; s++) begin
      board = (s % 2 == 1) ? 32'h0000_0080 : 32'h0;
      wait_scan_done();
      tick();
      total++; if (changed !== 1'b0) begin bad++; $display("FAIL toggle_changed: scan %0d got %b want 0", s, changed); end
    end
    read_reg(OCC_ADDR, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL toggle_occ: got %h want 00000000", d); end
    board = 32'h0;
  endtask

  task automatic test_scan_count();
    logic [31:0] d;
    board = 32'h0;
    do_reset();
    repeat (4) wait_scan_done();
    tick();
    read_reg(STAT_ADDR, d);
    total++; if (d !== 32'h0004_0000) begin bad++; $display("FAIL count_four: got %h want 00040000", d); end
    force dut.scan_count_q = 16'hFFFF;
    #1;
    release dut.scan_count_q;
    read_reg(STAT_ADDR, d);
    total++; if (d !== 32'hFFFF_0000) begin bad++; $display("FAIL count_forced: got %h want ffff0000", d); end
    wait_scan_done();
    tick();
    read_reg(STAT_ADDR, d);
    total++; if (d !== 32'h0000_0000) begin bad++; $display("FAIL count_wrap: got %h want 00000000", d); end
  endtask

  task automatic test_coincide();
    logic [31:0] d;
    do_reset();
    board = 32'h0000_0080;
    repeat (3) wait_scan_done();
    bus_if.addr = OCC_ADDR;
    tick();
    d = bus_if.sensorDataOut;
    bus_if.addr = 32'h0;
    total++; if (d !== 32'h0) begin bad++; $display("FAIL coincide_old: got %h want 00000000", d); end
    total++; if (changed !== 1'b1) begin bad++; $display("FAIL coincide_changed: got %b want 1", changed); end
    read_reg(OCC_ADDR, d);
    total++; if (d !== 32'h0000_0080) begin bad++; $display("FAIL coincide_new: got %h want 00000080", d); end
    board = 32'h0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int          n;
    do_reset();
    board = 32'h0000_0008;
    repeat (2) wait_scan_done();
    n = 0;
    do begin
      tick();
      n++;
    end while (sel_out !== 5'd20 && n < 200);
    total++;
    if (sel_out !== 5'd20) begin bad++; $display("FAIL mid_reach_sel20: got %0d want 20", sel_out); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (sel_out !== 5'd0) begin bad++; $display("FAIL mid_sel: got %0d want 0", sel_out); end
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL mid_changed: got %b want 0", changed); end
    read_reg(STAT_ADDR, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_status: got %h want 00000000", d); end
    for (int s = 1; s <= 3; s++) begin
      wait_scan_done();
      tick();
      read_reg(OCC_ADDR, d);
      total++;
      if (d !== ((s < 3) ? 32'h0 : 32'h0000_0008)) begin
        bad++;
        $display("FAIL mid_refresh: scan %0d got %h want %h", s, d, (s < 3) ? 32'h0 : 32'h0000_0008);
      end
    end
    board = 32'h0;
  endtask

  initial begin
    bus_if.addr = 32'h0;
    test_reset();
    test_scan_timing();
    test_debounce_hold();
    test_decode();
    test_toggle();
    test_scan_count();
    test_coincide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
